// File: rtl/conv_stream_scheduler.sv
// Sequences kernel load, window fill, operator job issue and result forwarding for one conv frame.
// Job issue is one cycle after the last window sample; every stage holds on its own handshake and has no combinational valid/ready path.
module conv_stream_scheduler #(
  parameter int CNT_W = 16,
  parameter int WIDTH = 64,
  parameter int LEN   = 4,
  parameter int RES_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_frame_len,
  input  logic                 cfg_reload_k,
  input  logic [WIDTH-1:0]     k_data,
  input  logic                 k_valid,
  output logic                 k_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [LEN*WIDTH-1:0] op_kernel,
  output logic [LEN*WIDTH-1:0] op_data,
  output logic                 op_in_valid,
  input  logic                 op_in_ready,
  input  logic [RES_W-1:0]     op_result,
  input  logic                 op_out_valid,
  output logic                 op_out_ready,
  output logic [RES_W-1:0]     res_data,
  output logic                 res_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int KI_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int FC_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADK, S_FILL, S_ISSUE, S_WAIT, S_OUT
  } state_t;

  state_t                     state_q, state_d;
  logic [LEN-1:0][WIDTH-1:0]  kernel_q, kernel_d;
  logic [LEN-1:0][WIDTH-1:0]  window_q, window_d;
  logic [KI_W-1:0]            k_idx_q, k_idx_d;
  logic                       k_loaded_q, k_loaded_d;
  logic [CNT_W-1:0]           frame_len_q, frame_len_d;
  logic [CNT_W-1:0]           consumed_q, consumed_d;
  logic [FC_W-1:0]            fill_cnt_q, fill_cnt_d;
  logic                       first_q, first_d;
  logic [RES_W-1:0]           res_data_q, res_data_d;
  logic                       res_last_q, res_last_d;
  logic                       cfg_err_q, cfg_err_d;
  logic [FC_W-1:0]            fill_target;

  // The first window of a frame needs LEN fresh samples, later windows slide by one.
  assign fill_target = first_q ? FC_W'(LEN) : FC_W'(1);

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    window_d    = window_q;
    k_idx_d     = k_idx_q;
    k_loaded_d  = k_loaded_q;
    frame_len_d = frame_len_q;
    consumed_d  = consumed_q;
    fill_cnt_d  = fill_cnt_q;
    first_d     = first_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_frame_len < LEN_C) begin
            cfg_err_d = 1'b1;
          end else begin
            frame_len_d = cfg_frame_len;
            consumed_d  = '0;
            fill_cnt_d  = '0;
            first_d     = 1'b1;
            if (cfg_reload_k || !k_loaded_q) begin
              k_idx_d = '0;
              state_d = S_LOADK;
            end else begin
              state_d = S_FILL;
            end
          end
        end
      end
      S_LOADK: begin
        if (k_valid) begin
          kernel_d[k_idx_q] = k_data;
          k_idx_d           = k_idx_q + KI_W'(1);
          if (k_idx_q == KI_W'(LEN - 1)) begin
            k_loaded_d = 1'b1;
            state_d    = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (s_valid) begin
          // Newest sample enters the top lane; lane 0 ends up holding the oldest.
          window_d   = {s_data, window_q[LEN-1:1]};
          consumed_d = consumed_q + CNT_W'(1);
          if (fill_cnt_q + FC_W'(1) == fill_target) begin
            fill_cnt_d = '0;
            first_d    = 1'b0;
            state_d    = S_ISSUE;
          end else begin
            fill_cnt_d = fill_cnt_q + FC_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (op_in_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_out_valid) begin
          res_data_d = op_result;
          res_last_d = (consumed_q == frame_len_q);
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_last_d = 1'b0;
          state_d    = res_last_q ? S_IDLE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kernel_q    <= '0;
      window_q    <= '0;
      k_idx_q     <= '0;
      k_loaded_q  <= 1'b0;
      frame_len_q <= '0;
      consumed_q  <= '0;
      fill_cnt_q  <= '0;
      first_q     <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      window_q    <= window_d;
      k_idx_q     <= k_idx_d;
      k_loaded_q  <= k_loaded_d;
      frame_len_q <= frame_len_d;
      consumed_q  <= consumed_d;
      fill_cnt_q  <= fill_cnt_d;
      first_q     <= first_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign k_ready      = (state_q == S_LOADK);
  assign s_ready      = (state_q == S_FILL);
  assign op_in_valid  = (state_q == S_ISSUE);
  assign op_out_ready = (state_q == S_WAIT);
  assign res_valid    = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);
  assign op_kernel    = kernel_q;
  assign op_data      = window_q;
  assign res_data     = res_data_q;
  assign res_last     = res_last_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_conv_stream_scheduler.sv
// Scoreboard bench for conv_stream_scheduler with a behavioural operator and kernel/sample sources.
module tb_conv_stream_scheduler;

  logic         clk, rst, start, cfg_reload_k;
  logic [15:0]  cfg_frame_len;
  logic [63:0]  k_data, s_data;
  logic         k_valid, k_ready, s_valid, s_ready;
  logic [255:0] op_kernel, op_data;
  logic         op_in_valid, op_in_ready, op_out_valid, op_out_ready;
  logic [127:0] op_result, res_data;
  logic         res_last, res_valid, res_ready, busy, cfg_err;

  conv_stream_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_frame_len(cfg_frame_len),
    .cfg_reload_k(cfg_reload_k), .k_data(k_data), .k_valid(k_valid), .k_ready(k_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .op_kernel(op_kernel), .op_data(op_data), .op_in_valid(op_in_valid),
    .op_in_ready(op_in_ready), .op_result(op_result), .op_out_valid(op_out_valid),
    .op_out_ready(op_out_ready), .res_data(res_data), .res_last(res_last),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] kq[$];
  logic [63:0] sq[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          op_stall = 0;
  int          op_lat = 1;
  int          op_jobs = 0;
  bit          op_flush = 0;
  bit          op_busy = 0;
  bit          k_seen = 0;
  bit          k_fire, s_fire;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    k_valid = 0; k_data = '0;
    forever begin
      @(negedge clk); k_fire = k_valid && k_ready;
      @(posedge clk); #1;
      if (k_fire && kq.size() > 0) void'(kq.pop_front());
      k_valid = (kq.size() > 0);
      k_data  = k_valid ? kq[0] : '0;
    end
  end

  initial begin
    s_valid = 0; s_data = '0;
    forever begin
      @(negedge clk); s_fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (s_fire && sq.size() > 0) void'(sq.pop_front());
      s_valid = (sq.size() > 0);
      s_data  = s_valid ? sq[0] : '0;
    end
  end

  // Behavioural operator: optional input stall, fixed latency, one job at a time.
  initial begin
    logic [127:0] acc;
    op_in_ready = 0; op_out_valid = 0; op_result = '0;
    forever begin
      @(negedge clk);
      if (op_in_valid && rst) begin
        op_busy = 1;
        repeat (op_stall) @(negedge clk);
        acc = '0;
        for (int i = 0; i < 4; i++)
          acc += 128'(op_kernel[i*64 +: 64]) * 128'(op_data[i*64 +: 64]);
        op_in_ready = 1;
        @(negedge clk);
        op_in_ready = 0;
        op_jobs++;
        repeat (op_lat) @(negedge clk);
        op_result = acc; op_out_valid = 1;
        while (!op_out_ready && !op_flush) @(negedge clk);
        @(negedge clk);
        op_out_valid = 0; op_busy = 0;
      end
    end
  end

  task automatic load_frame(input bit push_k, input logic [255:0] kern, input int s0, input int len);
    exp_t e;
    if (push_k) for (int i = 0; i < 4; i++) kq.push_back(kern[i*64 +: 64]);
    for (int i = 0; i < len; i++) sq.push_back(64'(s0 + i));
    for (int w = 0; w <= len - 4; w++) begin
      e.d = '0;
      for (int i = 0; i < 4; i++) e.d += 128'(kern[i*64 +: 64]) * 128'(s0 + w + i);
      e.last = (w == len - 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input bit reload, input int len);
    @(posedge clk); #1;
    start = 1; cfg_frame_len = 16'(len); cfg_reload_k = reload;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain(input int n, input string name);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    while (got < n && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (k_ready) k_seen = 1;
      if (res_valid && res_ready) begin
        got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL %s unexpected_result: got %0d, expected none", name, res_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (res_data !== e.d) begin
            n_mis++; $display("FAIL %s res_data: got %0d, expected %0d", name, res_data, e.d);
          end
          n_cmp++;
          if (res_last !== e.last) begin
            n_mis++; $display("FAIL %s res_last: got %0b, expected %0b", name, res_last, e.last);
          end
        end
      end
    end
    if (got < n) begin
      n_cmp++; n_mis++;
      $display("FAIL %s timeout: got %0d results, expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({k_ready, s_ready, op_in_valid, op_out_ready, res_valid, res_last, busy, cfg_err} !== 8'h00) begin
      n_mis++; $display("FAIL reset_ctrl: got %b, expected 00000000",
        {k_ready, s_ready, op_in_valid, op_out_ready, res_valid, res_last, busy, cfg_err});
    end
    n_cmp++;
    if (res_data !== '0 || op_kernel !== '0 || op_data !== '0) begin
      n_mis++; $display("FAIL reset_data: got %0h/%0h/%0h, expected 0", res_data, op_kernel, op_data);
    end
    #2 rst = 1;
  endtask

  task automatic test_basic_frame();
    load_frame(1, {64'd4, 64'd3, 64'd2, 64'd1}, 1, 6);
    do_start(1, 6);
    @(negedge clk);
    n_cmp++;
    if (k_ready !== 1'b1 || busy !== 1'b1) begin
      n_mis++; $display("FAIL basic_loadk: got k_ready=%b busy=%b, expected 1/1", k_ready, busy);
    end
    drain(3, "basic");
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++; $display("FAIL basic_busy_out: got %b, expected 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_mis++; $display("FAIL basic_busy_end: got busy=%b res_valid=%b, expected 0/0", busy, res_valid);
    end
  endtask

  task automatic test_no_reload();
    k_seen = 0;
    load_frame(0, {64'd4, 64'd3, 64'd2, 64'd1}, 2, 4);
    do_start(0, 4);
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || k_ready !== 1'b0) begin
      n_mis++; $display("FAIL noreload_fill: got s_ready=%b k_ready=%b, expected 1/0", s_ready, k_ready);
    end
    drain(1, "noreload");
    n_cmp++;
    if (k_seen !== 1'b0) begin
      n_mis++; $display("FAIL noreload_kready: got k_ready seen=%b, expected 0", k_seen);
    end
  endtask

  task automatic test_cfg_err();
    bit hs = 0;
    do_start(1, 3);
    @(negedge clk);
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_mis++; $display("FAIL cfgerr_pulse: got cfg_err=%b busy=%b, expected 1/0", cfg_err, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_mis++; $display("FAIL cfgerr_width: got %b, expected 0", cfg_err);
    end
    repeat (4) begin
      if (k_ready || s_ready || op_in_valid || op_out_ready || res_valid || busy) hs = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (hs !== 1'b0) begin
      n_mis++; $display("FAIL cfgerr_idle: got handshake activity=%b, expected 0", hs);
    end
  endtask

  task automatic test_backpressure();
    int   cyc = 0;
    exp_t e;
    res_ready = 0;
    load_frame(0, {64'd4, 64'd3, 64'd2, 64'd1}, 1, 6);
    do_start(0, 6);
    while (!res_valid && cyc < 200) begin @(negedge clk); cyc++; end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== e.d || res_last !== 1'b0 || s_ready !== 1'b0) begin
        n_mis++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0d last=%b s_ready=%b, expected 1/%0d/0/0",
          i, res_valid, res_data, res_last, s_ready, e.d);
      end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_mis++; $display("FAIL bp_release: got s_ready=%b res_valid=%b, expected 1/0", s_ready, res_valid);
    end
    drain(2, "bp_rest");
  endtask

  task automatic test_op_stall();
    int           cyc = 0;
    int           jobs0;
    logic [255:0] snap_k, snap_d, want_d;
    jobs0 = op_jobs;
    op_stall = 5;
    want_d = {64'd5, 64'd4, 64'd3, 64'd2};
    load_frame(0, {64'd4, 64'd3, 64'd2, 64'd1}, 2, 4);
    do_start(0, 4);
    while (!op_in_valid && cyc < 200) begin @(negedge clk); cyc++; end
    snap_k = op_kernel; snap_d = op_data;
    n_cmp++;
    if (snap_d !== want_d) begin
      n_mis++; $display("FAIL stall_window: got %0h, expected %0h", snap_d, want_d);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (op_in_valid !== 1'b1 || op_kernel !== snap_k || op_data !== snap_d) begin
        n_mis++; $display("FAIL stall_hold[%0d]: got valid=%b data=%0h, expected 1/%0h", i, op_in_valid, op_data, snap_d);
      end
    end
    drain(1, "stall");
    n_cmp++;
    if (op_jobs - jobs0 !== 1) begin
      n_mis++; $display("FAIL stall_jobs: got %0d, expected 1", op_jobs - jobs0);
    end
    op_stall = 0;
  endtask

  task automatic test_reset_in_wait();
    int cyc = 0;
    op_lat = 30;
    load_frame(1, {64'd4, 64'd3, 64'd2, 64'd1}, 2, 4);
    do_start(1, 4);
    while (!op_out_ready && cyc < 200) begin @(negedge clk); cyc++; end
    #2 rst = 0;
    #1;
    n_cmp++;
    if ({k_ready, s_ready, op_in_valid, op_out_ready, res_valid, res_last, busy, cfg_err} !== 8'h00
        || res_data !== '0 || op_kernel !== '0 || op_data !== '0) begin
      n_mis++; $display("FAIL rst_wait_outputs: got ctrl=%b data=%0h, expected all 0",
        {k_ready, s_ready, op_in_valid, op_out_ready, res_valid, res_last, busy, cfg_err}, op_data);
    end
    op_flush = 1;
    kq.delete(); sq.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1;
    cyc = 0;
    while (op_busy && cyc < 200) begin @(negedge clk); cyc++; end
    op_flush = 0;
    op_lat = 1;
    load_frame(1, {64'd1, 64'd1, 64'd1, 64'd1}, 1, 4);
    do_start(0, 4);
    @(negedge clk);
    n_cmp++;
    if (k_ready !== 1'b1) begin
      n_mis++; $display("FAIL rst_reload: got k_ready=%b, expected 1", k_ready);
    end
    drain(1, "after_rst");
  endtask

  initial begin
    rst = 0; start = 0; cfg_frame_len = '0; cfg_reload_k = 0; res_ready = 1;
    test_reset();
    test_basic_frame();
    test_no_reload();
    test_cfg_err();
    test_backpressure();
    test_op_stall();
    test_reset_in_wait();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/conv_stream_scheduler.md
# conv_stream_scheduler

Sequencing controller in front of the ConvOperator datapath. Loads a LEN-tap kernel, slides a LEN-sample window over an incoming sample stream, and issues one ConvOperator job per window position over the operator's valid/ready handshake. Collects each result and forwards it downstream with a frame-end marker. Operator results are unsigned sums of products: result = Σ kernel[i]·window[i].

## Interface
- CNT_W, 16, width of frame-length and sample counters
- (data word width Conv::WIDTH = 64, lanes Conv::LEN = 4, result Conv::result_t = 128 bits, all taken from the Conv package)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request, sampled in IDLE only
- cfg_frame_len  in  CNT_W  samples in frame, sampled with start
- cfg_reload_k  in  1  1 = load new kernel before frame, sampled with start
- k_data  in  Conv::WIDTH  kernel word
- k_valid / k_ready  in / out  1  kernel word handshake
- s_data  in  Conv::WIDTH  stream sample
- s_valid / s_ready  in / out  1  sample handshake
- op_kernel, op_data  out  Conv::data_vector  operator operands, lane i = kernel[i], window[i]
- op_in_valid / op_in_ready  out / in  1  operator job handshake
- op_result  in  Conv::result_t  operator result
- op_out_valid / op_out_ready  in / out  1  operator result handshake
- res_data  out  Conv::result_t  registered result
- res_last  out  1  qualifies last result of frame
- res_valid / res_ready  out / in  1  result handshake
- busy  out  1  state ≠ IDLE
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- A transfer on any handshake is valid && ready at a rising edge.
- Kernel register: LEN words, persists across frames; cleared by reset together with the k_loaded flag.
- Window: LEN-word shift register; a new sample enters lane LEN-1 and lanes shift toward 0, so lane 0 holds the oldest sample.
- States:
  - IDLE: start && (cfg_frame_len < LEN) → stay, pulse cfg_err. Else latch cfg_frame_len. Then if cfg_reload_k || !k_loaded → LOADK (k_idx = 0), else → FILL (fill_cnt = 0, consumed = 0).
  - LOADK: k_ready = 1. Each transfer writes kernel[k_idx] and increments k_idx. After the LEN-th word set k_loaded and go → FILL.
  - FILL: s_ready = 1. Each transfer shifts the window and increments consumed. The first window needs LEN samples; later windows need 1. When satisfied → ISSUE.
  - ISSUE: op_in_valid = 1, operands held stable. On transfer → WAIT.
  - WAIT: op_out_ready = 1. On transfer latch op_result into res_data. Set res_last = (consumed == frame_len). → OUT.
  - OUT: res_valid = 1. On transfer, if res_last → IDLE, else → FILL.
- At most one job in flight; op_kernel / op_data change only outside ISSUE.
- start, k_valid and s_valid outside their consuming states are ignored (ready = 0). No words are consumed.
- Number of results per frame = frame_len − LEN + 1.

## Timing
- Reset (rst = 0) from any state → IDLE immediately. All outputs 0: k_ready, s_ready, op_in_valid, op_out_ready, res_valid, res_last, res_data, busy, cfg_err, op_kernel, op_data. Window is cleared. An abandoned in-flight operator job is not tracked; the operator shares the same reset.
- All outputs are registered or decoded from the state register only. There are no combinational paths from ready/valid inputs to outputs.
- start in IDLE → LOADK/FILL the next cycle; k_ready / s_ready asserts in that cycle.
- Last window sample accepted at edge t → op_in_valid high from t+1.
- op_out_valid accepted at edge u → res_valid high from u+1.
- res_ready accepted at edge v → s_ready high from v+1 (next window), or busy low from v+1 (frame end).
- Backpressure on res_ready holds OUT indefinitely; res_data and res_last stay stable.
- With zero-wait handshakes, steady-state throughput is one result per (operator latency + 4) cycles.

## Test plan
- Load kernel {1,2,3,4}, frame_len 6, samples 1..6, all ready partners always ready → res_data 30, 40, 50 in order; res_last only with 50; busy falls after 50 is accepted.
- Repeat the frame with cfg_reload_k = 0 and samples 2..5 (frame_len 4) → no k_ready; single result 2+6+12+20 = 40 with res_last.
- start with cfg_frame_len = 3 → cfg_err pulses one cycle, busy stays 0, no handshakes asserted.
- Hold res_ready = 0 for 10 cycles during first result → res_valid and res_data 30 held stable, s_ready = 0 throughout; res_ready = 1 → s_ready high next cycle.
- Assert rst = 0 while in WAIT → all outputs 0 asynchronously. A later start with cfg_reload_k = 0 goes to LOADK, since k_loaded was cleared.
- Stall op_in_ready low for 5 cycles in ISSUE → op_in_valid, op_kernel and op_data stable; exactly one job is transferred.
